usb_fifo_tx: RTL and testbench
==============================

Name: usb_fifo_tx

Overview:
- Downstream stage of the board pin/pattern generators.
- Accepts bytes over a valid/ready stream and buffers them in a small internal FIFO.
- Writes each byte to an FT245-style USB FIFO chip via its 8-bit data bus, WR strobe and TXE# flow-control pin.
- Lets pattern sources produce data without knowing the USB chip timing. Runs on the 50 MHz board clock.

Parameters:
- FIFO_DEPTH, 8: internal buffer entries; power of 2, minimum 2.
- SETUP_CYCLES, 2: clocks data is driven before WR rises; 1 to 15.
- WR_HIGH_CYCLES, 3: clocks WR is held high; 1 to 15.
- RECOVER_CYCLES, 4: clocks bus is released after a write before the next byte; 1 to 15.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high reset.
- in_data  in  8  byte from upstream source.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block can accept a byte this cycle.
- usb_data  out  8  byte driven to the USB chip data pins.
- usb_data_oe  out  1  tri-state enable for usb_data at top level.
- usb_wr  out  1  FT245 WR strobe, active high; the chip latches on the falling edge.
- usb_rd_n  out  1  FT245 RD#, held constant 1.
- usb_txe_n  in  1  FT245 TXE#; 0 means the chip can accept data. Asynchronous to clk.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- sent_count  out  16  bytes written to the chip; wraps at 65535 to 0.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset values (asserted asynchronously, immediately on reset high):
  - state IDLE; FIFO empty; fifo_level 0; sent_count 0.
  - usb_data 0x00; usb_data_oe 0; usb_wr 0; busy 0.
  - usb_rd_n 1; in_ready 1 once reset is released.
- TXE# synchronisation:
  - usb_txe_n passes through a 2-flop synchroniser, giving txe_s.
  - Both flops reset to 1, i.e. "chip not ready".
- FIFO:
  - in_ready = !full, registered-state based.
  - Push occurs when in_valid && in_ready.
  - Pop occurs only at the IDLE->SETUP transition.
  - Simultaneous push and pop leave fifo_level unchanged.
  - When full, a push is refused (in_ready 0) even if a pop happens in the same cycle.
  - Pointers wrap modulo FIFO_DEPTH.
  - No pop when empty; no overwrite ever.
- State machine (single down-counter cnt, 4 bits):
  - IDLE:
    - If FIFO is non-empty and txe_s==0: load head into usb_data, set usb_data_oe=1, cnt=SETUP_CYCLES-1, go to SETUP. The pop occurs on this transition.
    - Otherwise remain in IDLE.
  - SETUP: oe=1, wr=0. When cnt==0: set wr=1, cnt=WR_HIGH_CYCLES-1, go to STROBE. Otherwise decrement cnt.
  - STROBE: oe=1, wr=1. When cnt==0: set wr=0, increment sent_count, go to HOLD.
  - HOLD: exactly 1 cycle with oe=1, wr=0 and data unchanged. Then oe=0, cnt=RECOVER_CYCLES-1, go to RECOVER.
  - RECOVER: oe=0, wr=0. When cnt==0, go to IDLE.
- Timing per byte:
  - usb_data_oe is high for SETUP_CYCLES+WR_HIGH_CYCLES+1 clocks.
  - usb_wr is high for exactly WR_HIGH_CYCLES clocks.
  - usb_data is stable for the whole oe window.
- Throughput: minimum byte period is 1+SETUP_CYCLES+WR_HIGH_CYCLES+1+RECOVER_CYCLES clocks, which is 11 with the defaults.
- Latency: a byte pushed at edge N into an empty FIFO, with txe_s already 0, has usb_data_oe high after edge N+2.
- TXE# rising mid-transfer is ignored: the current cycle completes. TXE# is sampled only in IDLE.
- usb_data holds its last value while oe=0; the value is don't-care for the chip.
- Reset during any state aborts immediately:
  - usb_wr drops without completing the strobe.
  - The byte in flight is lost and sent_count is not incremented.
- sent_count wraps from 0xFFFF to 0x0000 with no flag.

Test Plan:
- Single byte: txe_n=0, push 0xA5 -> usb_data=0xA5 with oe high for 6 clocks, wr high for 3 clocks starting 2 clocks after oe rises, sent_count=1, busy returns 0 after 11 clocks.
- Burst fill: txe_n=1, push 10 bytes 0x01..0x0A back-to-back -> 8 accepted, in_ready 0 after the 8th, fifo_level=8. Release txe_n=0 -> bytes 0x01..0x08 appear in order at 11-clock spacing, fifo_level decrements to 0.
- Flow-control stall: txe_n=1 with 3 bytes queued -> no wr activity for 100 clocks. Drop txe_n -> first oe 2-4 clocks later.
- TXE# mid-write: raise txe_n during STROBE -> that byte completes (sent_count increments). The next byte waits until txe_n returns to 0.
- Reset mid-strobe: assert reset during STROBE -> wr, oe, fifo_level and sent_count all 0 immediately. No further writes until new bytes are pushed.
- Push/pop collision at full-minus-one: level 7, push during the IDLE->SETUP pop -> level stays 7. At level 8 a push coinciding with a pop is refused.

Source files
------------

// File: rtl/usb_fifo_tx.sv
`default_nettype none
// ============================================================================
// Module   : usb_fifo_tx
// Purpose  : Buffers a byte stream and writes it to an FT245-style USB FIFO.
// Revision : 1.0
// ============================================================================
module usb_fifo_tx #(
  parameter int FIFO_DEPTH     = 8,
  parameter int SETUP_CYCLES   = 2,
  parameter int WR_HIGH_CYCLES = 3,
  parameter int RECOVER_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [7:0]                    usb_data,
  output logic                          usb_data_oe,
  output logic                          usb_wr,
  output logic                          usb_rd_n,
  input  logic                          usb_txe_n,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   sent_count,
  output logic                          busy
);

  localparam int                C_AW         = $clog2(FIFO_DEPTH);
  localparam logic [C_AW-1:0]   C_PTR_ONE    = C_AW'(1);
  localparam logic [C_AW:0]     C_LVL_ONE    = (C_AW+1)'(1);
  localparam logic [C_AW:0]     C_FULL       = (C_AW+1)'(FIFO_DEPTH);
  localparam logic [3:0]        C_SETUP_LOAD = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0]        C_WR_LOAD    = 4'(WR_HIGH_CYCLES - 1);
  localparam logic [3:0]        C_REC_LOAD   = 4'(RECOVER_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_STROBE  = 3'd2,
    ST_HOLD    = 3'd3,
    ST_RECOVER = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [7:0]      data_q, data_d;
  logic            oe_q, oe_d;
  logic            wr_q, wr_d;
  logic [15:0]     sent_q, sent_d;
  logic            txe_meta_q, txe_s_q;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [C_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [C_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [C_AW:0]   level_q, level_d;
  logic            avail_q, avail_d;
  logic            push;
  logic            pop;

  assign in_ready = (level_q != C_FULL);
  assign push     = in_valid && in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      txe_meta_q <= 1'b1;
      txe_s_q    <= 1'b1;
    end else begin
      txe_meta_q <= usb_txe_n;
      txe_s_q    <= txe_meta_q;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    // Registered non-empty view: a fresh byte reaches the bus two edges after its push.
    avail_d  = (level_q != '0);
    if (push) wr_ptr_d = wr_ptr_q + C_PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + C_PTR_ONE;
    case ({push, pop})
      2'b10:   level_d = level_q + C_LVL_ONE;
      2'b01:   level_d = level_q - C_LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    oe_d    = oe_q;
    wr_d    = wr_q;
    sent_d  = sent_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (avail_q && !txe_s_q) begin
          pop     = 1'b1;
          data_d  = mem_q[rd_ptr_q];
          oe_d    = 1'b1;
          cnt_d   = C_SETUP_LOAD;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_q == 4'd0) begin
          wr_d    = 1'b1;
          cnt_d   = C_WR_LOAD;
          state_d = ST_STROBE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_STROBE: begin
        if (cnt_q == 4'd0) begin
          wr_d    = 1'b0;
          sent_d  = sent_q + 16'd1;
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_HOLD: begin
        oe_d    = 1'b0;
        cnt_d   = C_REC_LOAD;
        state_d = ST_RECOVER;
      end
      ST_RECOVER: begin
        if (cnt_q == 4'd0) state_d = ST_IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: begin
        oe_d    = 1'b0;
        wr_d    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      data_q   <= 8'h00;
      oe_q     <= 1'b0;
      wr_q     <= 1'b0;
      sent_q   <= 16'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      avail_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      oe_q     <= oe_d;
      wr_q     <= wr_d;
      sent_q   <= sent_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      avail_q  <= avail_d;
    end
  end

  assign usb_data    = data_q;
  assign usb_data_oe = oe_q;
  assign usb_wr      = wr_q;
  assign usb_rd_n    = 1'b1;
  assign fifo_level  = level_q;
  assign sent_count  = sent_q;
  assign busy        = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_usb_fifo_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_usb_fifo_tx
// Purpose  : Directed vector bench for usb_fifo_tx with default parameters.
// Revision : 1.0
// ============================================================================
module tb_usb_fifo_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  usb_data;
  logic        usb_data_oe;
  logic        usb_wr;
  logic        usb_rd_n;
  logic        usb_txe_n;
  logic [3:0]  fifo_level;
  logic [15:0] sent_count;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int cyc_n    = 0;

  always #10 clk = ~clk;

  usb_fifo_tx #(
    .FIFO_DEPTH    (8),
    .SETUP_CYCLES  (2),
    .WR_HIGH_CYCLES(3),
    .RECOVER_CYCLES(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .usb_data   (usb_data),
    .usb_data_oe(usb_data_oe),
    .usb_wr     (usb_wr),
    .usb_rd_n   (usb_rd_n),
    .usb_txe_n  (usb_txe_n),
    .fifo_level (fifo_level),
    .sent_count (sent_count),
    .busy       (busy)
  );

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic       oe;
    logic       wr;
    logic       bsy;
    logic       rdy;
    int         level;
    int         sent;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // One active edge, landing on the following falling edge for sampling.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    cyc_n++;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    usb_txe_n = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
  endtask

  task automatic push_bytes(input int n, input int base);
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b1;
      in_data  = 8'(base + k);
      cyc();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_oe(input int budget, output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (n < budget && !ok) begin
      cyc();
      n++;
      if (usb_data_oe) ok = 1'b1;
    end
  endtask

  task automatic walk_oe(output int oe_n, output int wr_n);
    int tmo;
    oe_n = 0;
    wr_n = 0;
    tmo  = 0;
    while (usb_data_oe && tmo < 40) begin
      oe_n++;
      if (usb_wr) wr_n++;
      cyc();
      tmo++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n, oe_n, wr_n, act, bad, t_prev;
    bit  ok;

    // Asynchronous reset state, before any clock edge.
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    usb_txe_n = 1'b1;
    #5;
    check("rst_wr",    usb_wr, 0);
    check("rst_oe",    usb_data_oe, 0);
    check("rst_busy",  busy, 0);
    check("rst_level", fifo_level, 0);
    check("rst_sent",  sent_count, 0);
    check("rst_data",  usb_data, 8'h00);
    check("rst_rd_n",  usb_rd_n, 1);
    do_reset();
    check("rst_ready", in_ready, 1);

    // ---------------- single byte, cycle by cycle ----------------
    //            valid data   oe wr bsy rdy lvl sent
    vecs[0]  = '{1'b1, 8'hA5, 0, 0, 0, 1, 1, 0};
    vecs[1]  = '{1'b0, 8'h00, 0, 0, 0, 1, 1, 0};
    vecs[2]  = '{1'b0, 8'h00, 1, 0, 1, 1, 0, 0};
    vecs[3]  = '{1'b0, 8'h00, 1, 0, 1, 1, 0, 0};
    vecs[4]  = '{1'b0, 8'h00, 1, 1, 1, 1, 0, 0};
    vecs[5]  = '{1'b0, 8'h00, 1, 1, 1, 1, 0, 0};
    vecs[6]  = '{1'b0, 8'h00, 1, 1, 1, 1, 0, 0};
    vecs[7]  = '{1'b0, 8'h00, 1, 0, 1, 1, 0, 1};
    vecs[8]  = '{1'b0, 8'h00, 0, 0, 1, 1, 0, 1};
    vecs[9]  = '{1'b0, 8'h00, 0, 0, 1, 1, 0, 1};
    vecs[10] = '{1'b0, 8'h00, 0, 0, 1, 1, 0, 1};
    vecs[11] = '{1'b0, 8'h00, 0, 0, 1, 1, 0, 1};
    vecs[12] = '{1'b0, 8'h00, 0, 0, 0, 1, 0, 1};

    usb_txe_n = 1'b0;
    cyc(); cyc(); cyc();
    for (int i = 0; i < 13; i++) begin
      in_valid = vecs[i].valid;
      in_data  = vecs[i].data;
      cyc();
      check($sformatf("v%0d_oe", i),    usb_data_oe, vecs[i].oe);
      check($sformatf("v%0d_wr", i),    usb_wr,      vecs[i].wr);
      check($sformatf("v%0d_busy", i),  busy,        vecs[i].bsy);
      check($sformatf("v%0d_ready", i), in_ready,    vecs[i].rdy);
      check($sformatf("v%0d_level", i), fifo_level,  vecs[i].level);
      check($sformatf("v%0d_sent", i),  sent_count,  vecs[i].sent);
      if (vecs[i].oe) check($sformatf("v%0d_data", i), usb_data, 8'hA5);
    end

    // ---------------- burst fill, stall, TXE# mid-write ----------------
    do_reset();
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      in_data  = 8'(k + 1);
      check($sformatf("burst_ready%0d", k), in_ready, (k < 8) ? 1 : 0);
      cyc();
    end
    in_valid = 1'b0;
    check("burst_level", fifo_level, 8);
    check("burst_full_ready", in_ready, 0);

    act = 0;
    repeat (100) begin
      cyc();
      if (usb_wr || usb_data_oe) act++;
    end
    check("stall_activity", act, 0);
    check("stall_level", fifo_level, 8);

    usb_txe_n = 1'b0;
    wait_oe(50, n, ok);
    check("stall_release_timeout", ok, 1);
    check("stall_release_lat_2to4", (n >= 2 && n <= 4) ? 1 : 0, 1);

    t_prev = cyc_n;
    for (int k = 0; k < 8; k++) begin
      if (k > 0 && k != 3) check($sformatf("byte%0d_period", k), cyc_n - t_prev, 11);
      t_prev = cyc_n;
      check($sformatf("byte%0d_data", k), usb_data, k + 1);
      check($sformatf("byte%0d_level", k), fifo_level, 7 - k);
      oe_n = 0;
      wr_n = 0;
      bad  = 0;
      while (usb_data_oe && oe_n < 40) begin
        oe_n++;
        if (usb_wr) begin
          wr_n++;
          if (k == 2) usb_txe_n = 1'b1;
        end
        if (usb_data != 8'(k + 1)) bad++;
        cyc();
      end
      check($sformatf("byte%0d_oe_len", k), oe_n, 6);
      check($sformatf("byte%0d_wr_len", k), wr_n, 3);
      check($sformatf("byte%0d_stable", k), bad, 0);
      check($sformatf("byte%0d_sent", k), sent_count, k + 1);
      if (k == 2) begin
        act = 0;
        repeat (30) begin
          cyc();
          if (usb_data_oe || usb_wr) act++;
        end
        check("txe_holdoff", act, 0);
        usb_txe_n = 1'b0;
      end
      if (k < 7) begin
        wait_oe(60, n, ok);
        check($sformatf("byte%0d_next_timeout", k), ok, 1);
      end
    end
    repeat (6) cyc();
    check("burst_end_level", fifo_level, 0);
    check("burst_end_sent", sent_count, 8);
    check("burst_end_busy", busy, 0);

    // ---------------- reset mid-strobe ----------------
    do_reset();
    usb_txe_n = 1'b0;
    cyc(); cyc(); cyc();
    push_bytes(3, 8'h11);
    wait_oe(20, n, ok);
    check("rst_mid_first_timeout", ok, 1);
    walk_oe(oe_n, wr_n);
    wait_oe(20, n, ok);
    check("rst_mid_second_timeout", ok, 1);
    n = 0;
    while (!usb_wr && n < 10) begin
      cyc();
      n++;
    end
    check("rst_mid_in_strobe", usb_wr, 1);
    check("rst_mid_pre_sent", sent_count, 1);
    check("rst_mid_pre_level", fifo_level, 1);
    #3;
    reset = 1'b1;
    #1;
    check("rst_mid_wr", usb_wr, 0);
    check("rst_mid_oe", usb_data_oe, 0);
    check("rst_mid_level", fifo_level, 0);
    check("rst_mid_sent", sent_count, 0);
    check("rst_mid_busy", busy, 0);
    @(negedge clk);
    reset = 1'b0;
    act = 0;
    repeat (40) begin
      cyc();
      if (usb_data_oe || usb_wr) act++;
    end
    check("rst_mid_quiet", act, 0);
    push_bytes(1, 8'h44);
    wait_oe(10, n, ok);
    check("rst_mid_new_timeout", ok, 1);
    check("rst_mid_new_data", usb_data, 8'h44);

    // ---------------- push/pop collision at level 7 ----------------
    do_reset();
    push_bytes(7, 8'h30);
    check("coll7_pre_level", fifo_level, 7);
    cyc(); cyc();
    usb_txe_n = 1'b0;
    cyc(); cyc();
    in_valid = 1'b1;
    in_data  = 8'h77;
    cyc();
    in_valid = 1'b0;
    check("coll7_pop_now", usb_data_oe, 1);
    check("coll7_level", fifo_level, 7);
    check("coll7_data", usb_data, 8'h30);

    // ---------------- push refused at level 8 despite pop ----------------
    do_reset();
    push_bytes(8, 8'h50);
    check("coll8_pre_level", fifo_level, 8);
    cyc(); cyc();
    usb_txe_n = 1'b0;
    cyc(); cyc();
    in_valid = 1'b1;
    in_data  = 8'hEE;
    check("coll8_ready", in_ready, 0);
    cyc();
    in_valid = 1'b0;
    check("coll8_pop_now", usb_data_oe, 1);
    check("coll8_level", fifo_level, 7);
    check("coll8_ready_after", in_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
